pong_engine: RTL



---
 rtl/pong_pkg.sv | 10 +
 rtl/pong_tick_gen.sv | 43 ++++
 rtl/pong_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, data_out select codes and direction constants.
package pong_pkg;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;
  localparam logic [1:0] SEL_BX = 2'd0;
  localparam logic [1:0] SEL_BY = 2'd1;
  localparam logic [1:0] SEL_PL = 2'd2;
  localparam logic [1:0] SEL_PR = 2'd3;
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;
endpackage

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: free-running tick divider; with PONG_SPEEDUP_EN a hit-driven speed level shortens the period.
module pong_tick_gen #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PONG_SPEEDUP_EN
  input  logic         hit_i,
  input  logic         clr_i,
`endif
  input  logic [W-1:0] period_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] period;
`ifdef PONG_SPEEDUP_EN
  logic [1:0]   level_q, level_d;
  logic [W-1:0] period_q, shifted, period_d;
  always_comb begin
    level_d  = clr_i ? 2'd0 : (hit_i && level_q != 2'd3) ? level_q + 2'd1 : level_q;
    shifted  = period_i >> level_d;
    period_d = shifted == '0 ? W'(1) : shifted;
  end
  // New period is latched only on a wrap so the current count always completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= 2'd0;
      period_q <= period_i;
    end else begin
      level_q <= level_d;
      if (tick_o) period_q <= period_d;
    end
  end
  assign period = period_q;
`else
  assign period = period_i;
`endif
  assign tick_o = cnt_q == period - 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/pong_engine.sv
// pong_engine: two-player pong core with clamped paddles, scoring and a serve/point/over FSM.
// Optional macro PONG_SPEEDUP_EN: each paddle hit shortens the tick period.
module pong_engine
  import pong_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int PADDLE_HALF = 8,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 5,
  parameter int TICK_DIV    = 4,
  parameter int HOLD_TICKS  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               l_up,
  input  logic               l_down,
  input  logic               r_up,
  input  logic               r_down,
  input  logic [1:0]         out_sel,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_l,
  output logic [COORD_W-1:0] paddle_r,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state,
  output logic               tick,
  output logic [COORD_W-1:0] data_out
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [COORD_W-1:0] CX   = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] CY   = COORD_W'(SCREEN_H / 2);
  localparam logic [COORD_W-1:0] PH   = COORD_W'(PADDLE_HALF);
  localparam logic [COORD_W-1:0] PMAX = COORD_W'(SCREEN_H - 1 - PADDLE_HALF);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] XR2  = COORD_W'(SCREEN_W - 2);
  localparam logic [COORD_W-1:0] XR3  = COORD_W'(SCREEN_W - 3);
  localparam logic [COORD_W-1:0] XR1  = COORD_W'(SCREEN_W - 1);

  state_t               state_q;
  logic [COORD_W-1:0]   bx_q, by_q, pl_q, pr_q, dout_q;
  logic [SCORE_W-1:0]   sl_q, sr_q;
  logic [HW-1:0]        hold_q;
  logic                 vx_q, vy_q;
  logic [COORD_W-1:0]   dl, dr, x_n, y_n;
  logic                 hit_l, hit_r, at_l, at_r, bounce, vx_n, vy_n, hold_done, game_won;

  function automatic logic [COORD_W-1:0] move_pad(input logic [COORD_W-1:0] p, input logic up, input logic dn);
    return (up && !dn && p > PH) ? p - 1'b1 : (dn && !up && p < PMAX) ? p + 1'b1 : p;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return &s ? s : s + 1'b1;
  endfunction

  always_comb begin
    dl        = by_q > pl_q ? by_q - pl_q : pl_q - by_q;
    dr        = by_q > pr_q ? by_q - pr_q : pr_q - by_q;
    hit_l     = dl <= PH;
    hit_r     = dr <= PH;
    at_l      = bx_q == COORD_W'(1) && vx_q == DIR_NEG;
    at_r      = bx_q == XR2 && vx_q == DIR_POS;
    bounce    = (by_q == '0 && vy_q == DIR_NEG) || (by_q == YMAX && vy_q == DIR_POS);
    vy_n      = vy_q ^ bounce;
    y_n       = vy_n == DIR_POS ? by_q + 1'b1 : by_q - 1'b1;
    x_n       = at_l ? (hit_l ? COORD_W'(2) : '0) : at_r ? (hit_r ? XR3 : XR1) :
                (vx_q == DIR_POS ? bx_q + 1'b1 : bx_q - 1'b1);
    vx_n      = (at_l && hit_l) ? DIR_POS : (at_r && hit_r) ? DIR_NEG : vx_q;
    hold_done = hold_q == HW'(HOLD_TICKS - 1);
    game_won  = sl_q == SCORE_W'(WIN_SCORE) || sr_q == SCORE_W'(WIN_SCORE);
  end

`ifdef PONG_SPEEDUP_EN
  logic paddle_hit, to_serve;
  always_comb begin
    paddle_hit = tick && state_q == PLAY && ((at_l && hit_l) || (at_r && hit_r));
    to_serve   = (state_q == POINT && tick && hold_done && !game_won) || (state_q == OVER && start);
  end
`endif

  pong_tick_gen #(.W(PW)) u_tick (
    .clk      (clk),
    .rst      (rst),
`ifdef PONG_SPEEDUP_EN
    .hit_i    (paddle_hit),
    .clr_i    (to_serve),
`endif
    .period_i (PW'(TICK_DIV)),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE;
      bx_q    <= CX;
      by_q    <= CY;
      pl_q    <= CY;
      pr_q    <= CY;
      sl_q    <= '0;
      sr_q    <= '0;
      vx_q    <= DIR_POS;
      vy_q    <= DIR_POS;
      hold_q  <= '0;
      dout_q  <= '0;
    end else begin
      dout_q <= out_sel == SEL_BX ? bx_q : out_sel == SEL_BY ? by_q : out_sel == SEL_PL ? pl_q : pr_q;
      if (tick && state_q != OVER) begin
        pl_q <= move_pad(pl_q, l_up, l_down);
        pr_q <= move_pad(pr_q, r_up, r_down);
      end
      case (state_q)
        SERVE: if (start) state_q <= PLAY;
        PLAY: if (tick) begin
          bx_q   <= x_n;
          by_q   <= y_n;
          vx_q   <= vx_n;
          vy_q   <= vy_n;
          hold_q <= '0;
          if (at_l && !hit_l) begin
            sr_q    <= sat_inc(sr_q);
            state_q <= POINT;
          end
          if (at_r && !hit_r) begin
            sl_q    <= sat_inc(sl_q);
            state_q <= POINT;
          end
        end
        POINT: if (tick) begin
          hold_q <= hold_q + 1'b1;
          if (hold_done && game_won) state_q <= OVER;
          else if (hold_done) begin
            state_q <= SERVE;
            bx_q    <= CX;
            by_q    <= CY;
            vx_q    <= bx_q == '0 ? DIR_POS : DIR_NEG;
            vy_q    <= DIR_POS;
          end
        end
        default: if (start) begin
          state_q <= SERVE;
          sl_q    <= '0;
          sr_q    <= '0;
          bx_q    <= CX;
          by_q    <= CY;
          vx_q    <= DIR_POS;
          vy_q    <= DIR_POS;
        end
      endcase
    end
  end

  assign ball_x   = bx_q;
  assign ball_y   = by_q;
  assign paddle_l = pl_q;
  assign paddle_r = pr_q;
  assign score_l  = sl_q;
  assign score_r  = sr_q;
  assign state    = state_q;
  assign data_out = dout_q;
endmodule
